ccff_bitstream_loader: RTL and testbench
========================================

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8: width of an input bitstream word.
REQ-002 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the target chain (CHAIN_LEN >= 1).
REQ-003 SHALL have port prog_clk  input  1  programming clock; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins a load session.
REQ-006 SHALL have port in_data  input  WORD_W  bitstream word; bit 0 is shifted out first.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port ccff_head  output  1  serial bit into the configuration chain head.
REQ-010 SHALL have port ccff_shift_en  output  1  high on every cycle the chain must shift.
REQ-011 SHALL have port busy  output  1  session in progress.
REQ-012 SHALL have port done  output  1  chain fully loaded; held until next start or reset.
REQ-013 SHALL have port bit_count  output  clog2(CHAIN_LEN+1)  number of bits shifted in the current session.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: in_ready=0, ccff_shift_en=0; start -> LOAD, bit_count cleared to 0, done cleared.
REQ-016 LOAD: in_ready=1; transfer occurs when in_valid && in_ready; word captured into a WORD_W shift register and bit pointer set to 0; next state SHIFT.
REQ-017 SHIFT: each cycle drives ccff_head = shift_reg[0], asserts ccff_shift_en, increments bit_count, shifts register right by one with const 0 fill.
REQ-018 SHIFT -> DONE in the cycle after the bit that makes bit_count == CHAIN_LEN; any remaining bits of that word are discarded and are never driven onto ccff_head.
REQ-019 SHIFT -> LOAD after WORD_W bits of a word are shifted while bit_count < CHAIN_LEN.
REQ-020 Throughput: one word per WORD_W+1 cycles (one LOAD cycle plus WORD_W SHIFT cycles); no overlap of load and shift.
REQ-021 When ccff_shift_en=0, ccff_head SHALL be 0.
REQ-022 DONE: done=1, busy=0, in_ready=0, ccff_shift_en=0; bit_count holds CHAIN_LEN; start -> LOAD with a fresh session.
REQ-023 busy=1 exactly in LOAD and SHIFT.
REQ-024 start while busy SHALL be ignored.
REQ-025 in_valid while not in LOAD SHALL be ignored; data is not consumed.
REQ-026 A LOAD state with in_valid=0 SHALL wait indefinitely with no shifting and no counter change.
REQ-027 Total words consumed per session SHALL be ceil(CHAIN_LEN/WORD_W).

Reset
REQ-028 pReset SHALL take priority over every other input, including start in the same cycle.
REQ-029 On pReset: state IDLE, in_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bit_count=0, shift register 0.
REQ-030 pReset mid-session SHALL abort the session immediately; no further shift pulses; partial chain contents are not restored.

Verification
REQ-031 WORD_W=8, CHAIN_LEN=16, start, words 0xA5 then 0x3C with in_valid always high -> ccff_head with ccff_shift_en sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done rises after 18 shift/load cycles; bit_count=16.
REQ-032 CHAIN_LEN=12, words 0xFF, 0xFF -> exactly 12 ccff_shift_en pulses; upper 4 bits of word 2 are not shifted; done=1; in_ready stays 0 afterwards.
REQ-033 Withhold in_valid for 5 cycles in LOAD after the first word -> ccff_shift_en low and bit_count frozen at 8 throughout; the session resumes correctly.
REQ-034 Assert pReset at bit_count=5 of the first word -> next cycle state IDLE, all outputs 0; a new start loads the full CHAIN_LEN bits.
REQ-035 Pulse start during SHIFT and in the same cycle as pReset -> both ignored (state IDLE after pReset); start in DONE -> done cleared, bit_count=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_bitstream_loader
// Description : Streams WORD_W-bit bitstream words, LSB first, into a serial
//               configuration flip-flop chain of CHAIN_LEN bits. The loader
//               accepts one word, then shifts its bits out one per cycle. It
//               stops as soon as the chain is full and drops any leftover
//               bits of the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic                             prog_clk,
    input  logic                             pReset,
    input  logic                             start,
    input  logic [WORD_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             ccff_head,
    output logic                             ccff_shift_en,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int PTR_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    // Count value held while the final chain bit is on ccff_head.
    localparam logic [CNT_W-1:0] LAST_CHAIN_BIT = CNT_W'(CHAIN_LEN - 1);
    // Pointer value held while the final bit of a word is on ccff_head.
    localparam logic [PTR_W-1:0] LAST_WORD_BIT  = PTR_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [WORD_W-1:0]  shift_reg_q, shift_reg_d;
    logic [PTR_W-1:0]   bit_ptr_q,   bit_ptr_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= ST_IDLE;
            shift_reg_q <= '0;
            bit_ptr_q   <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_ptr_q   <= bit_ptr_d;
            bit_count_q <= bit_count_d;
        end
    end

    // Next-state and output decode. In LOAD the loader only accepts a word.
    // In SHIFT it only shifts. The two phases never overlap.
    always_comb begin
        state_d       = state_q;
        shift_reg_d   = shift_reg_q;
        bit_ptr_d     = bit_ptr_q;
        bit_count_d   = bit_count_q;
        in_ready      = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    bit_count_d = '0;
                end
            end

            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    shift_reg_d = in_data;
                    bit_ptr_d   = '0;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = shift_reg_q[0];
                shift_reg_d   = shift_reg_q >> 1;
                bit_ptr_d     = bit_ptr_q + 1'b1;
                bit_count_d   = bit_count_q + 1'b1;
                if (bit_count_q == LAST_CHAIN_BIT) begin
                    // Chain is full. Drop whatever is left of the word.
                    state_d     = ST_DONE;
                    shift_reg_d = '0;
                end else if (bit_ptr_q == LAST_WORD_BIT) begin
                    state_d = ST_LOAD;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d     = ST_LOAD;
                    bit_count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bit_count = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_bitstream_loader
// Description : Bench for ccff_bitstream_loader. Two instances share stimulus:
//               one with a 16-bit chain and one with a 12-bit chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    localparam int W   = 8;
    localparam int CL0 = 16;
    localparam int CL1 = 12;
    localparam int CW0 = $clog2(CL0 + 1);
    localparam int CW1 = $clog2(CL1 + 1);

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic         pReset, start, in_valid;
    logic [W-1:0] in_data;
    logic         rdy [2];
    logic         head[2];
    logic         sen [2];
    logic         bsy [2];
    logic         dn  [2];
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(CL0)) u_dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[0]), .ccff_head(head[0]),
        .ccff_shift_en(sen[0]), .busy(bsy[0]), .done(dn[0]), .bit_count(cnt0));

    ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(CL1)) u_dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[1]), .ccff_head(head[1]),
        .ccff_shift_en(sen[1]), .busy(bsy[1]), .done(dn[1]), .bit_count(cnt1));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: session state, bits pushed so far, and bits of the
    // current word still owed to the chain. Zero bits owed means the loader
    // is waiting for a word.
    int           m_cl    [2] = '{CL0, CL1};
    bit           m_act   [2];
    bit           m_done  [2];
    int           m_n     [2];
    int           m_avail [2];
    logic [W-1:0] m_word  [2];

    // Words handed over and bits observed on the chain in the current session.
    logic [W-1:0] sent  [2][16];
    int           sent_n[2];
    bit           got   [2][64];
    int           got_n [2];

    logic [W-1:0] feed[$];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s [dut%0d]: observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // The whole-session result: chain stream equals the accepted words' bits
    // LSB first, truncated to the chain length. Words used = ceil(len/W).
    task automatic session_check(input int i);
        logic [W-1:0] wv;
        chk("bits_shifted", i, got_n[i], m_cl[i]);
        chk("words_used", i, sent_n[i], (m_cl[i] + W - 1) / W);
        for (int k = 0; k < m_cl[i] && k < got_n[i]; k++) begin
            wv = sent[i][k / W];
            chk("stream_bit", i, got[i][k], wv[k % W]);
        end
    endtask

    task automatic model_edge(input int i, output bit acc);
        acc = 1'b0;
        if (pReset) begin
            m_act[i] = 0; m_done[i] = 0; m_n[i] = 0; m_avail[i] = 0; m_word[i] = '0;
        end else if (m_act[i]) begin
            if (m_avail[i] == 0) begin
                if (in_valid) begin
                    acc        = 1'b1;
                    m_word[i]  = in_data;
                    m_avail[i] = (m_cl[i] - m_n[i] < W) ? m_cl[i] - m_n[i] : W;
                    if (sent_n[i] < 16) sent[i][sent_n[i]] = in_data;
                    sent_n[i]++;
                end
            end else begin
                m_word[i] = m_word[i] >> 1;
                m_n[i]++;
                m_avail[i]--;
                if (m_n[i] == m_cl[i]) begin
                    m_act[i]  = 0;
                    m_done[i] = 1;
                    session_check(i);
                end
            end
        end else if (start) begin
            m_act[i] = 1; m_done[i] = 0; m_n[i] = 0; m_avail[i] = 0;
            got_n[i] = 0; sent_n[i] = 0;
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model on
    // the rising edge, then present the next data word.
    task automatic step();
        bit a0, a1;
        @(negedge prog_clk);
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, rdy[i], m_act[i] && m_avail[i] == 0);
            chk("shift_en", i, sen[i], m_act[i] && m_avail[i] > 0);
            chk("head", i, head[i], m_act[i] && m_avail[i] > 0 && m_word[i][0]);
            chk("busy", i, bsy[i], m_act[i]);
            chk("done", i, dn[i], m_done[i]);
            chk("bit_count", i, cnt_of(i), m_n[i]);
            if (sen[i] === 1'b1 && got_n[i] < 64) begin
                got[i][got_n[i]] = head[i];
                got_n[i]++;
            end
        end
        @(posedge prog_clk);
        model_edge(0, a0);
        model_edge(1, a1);
        #1;
        if ((a0 || a1) && feed.size() != 0) void'(feed.pop_front());
        in_data = (feed.size() != 0) ? feed[0] : W'($urandom);
    endtask

    task automatic run_to_idle(input int max_cycles);
        int c = 0;
        while ((m_act[0] || m_act[1]) && c < max_cycles) begin
            step();
            c++;
        end
        if (m_act[0] || m_act[1]) chk("session_timeout", 0, 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [15:0] seq16;
    int          cyc;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_done[i] = 0; m_n[i] = 0; m_avail[i] = 0;
            m_word[i] = '0; sent_n[i] = 0; got_n[i] = 0;
        end
        pReset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(posedge prog_clk); #1;
        step(); step();
        pReset = 1'b0;
        step();

        // Known pattern 0xA5, 0x3C with in_valid held high.
        feed = '{8'hA5, 8'h3C};
        in_data = feed[0];
        in_valid = 1'b1;
        pulse_start();
        cyc = 0;
        while (dn[0] !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("done_latency", 0, cyc, 18);
        chk("final_count", 0, cnt0, 16);
        seq16 = '0;
        for (int k = 0; k < 16; k++) seq16[k] = got[0][k];
        chk("head_seq16", 0, seq16, 16'h3CA5);
        seq16 = '0;
        for (int k = 0; k < 12; k++) seq16[k] = got[1][k];
        chk("head_seq12", 1, seq16, 16'h0CA5);
        run_to_idle(50);

        // Two all-ones words into the 12-bit chain: the top nibble of word 2 is dropped.
        feed = '{8'hFF, 8'hFF};
        in_data = feed[0];
        pulse_start();
        run_to_idle(100);
        chk("pulses12", 1, got_n[1], 12);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ready_after_done", 1, rdy[1], 0);
        end

        // Stall in LOAD for five cycles after the first word.
        feed = '{8'h5A, 8'hC3};
        in_data = feed[0];
        pulse_start();
        for (int k = 0; k < 9; k++) step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_count", 0, cnt0, 8);
            chk("stall_shift", 0, sen[0], 0);
        end
        in_valid = 1'b1;
        run_to_idle(100);

        // Reset while bit_count reads 5 partway through the first word.
        pulse_start();
        for (int k = 0; k < 6; k++) step();
        chk("pre_reset_count", 0, cnt0, 5);
        pReset = 1'b1;
        step();
        pReset = 1'b0;
        chk("abort_busy", 0, bsy[0], 0);
        chk("abort_shift", 0, sen[0], 0);
        chk("abort_count", 0, cnt0, 0);
        step();
        pulse_start();
        run_to_idle(100);

        // start during SHIFT, then start together with reset, then start in DONE.
        pulse_start();
        step(); step();
        pulse_start();
        pReset = 1'b1;
        pulse_start();
        pReset = 1'b0;
        chk("reset_over_start_busy", 0, bsy[0], 0);
        chk("reset_over_start_ready", 0, rdy[0], 0);
        step();
        pulse_start();
        run_to_idle(100);
        pulse_start();
        chk("restart_done", 0, dn[0], 0);
        chk("restart_count", 0, cnt0, 0);
        chk("restart_ready", 0, rdy[0], 1);
        run_to_idle(100);

        // Random traffic: stalls, stray starts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            if (!m_act[0] && !m_act[1]) start = ($urandom_range(0, 1) == 0);
            else                        start = ($urandom_range(0, 19) == 0);
            pReset = ($urandom_range(0, 299) == 0);
            step();
        end
        start = 1'b0; pReset = 1'b0; in_valid = 1'b1;
        run_to_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
